mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS core's execute stage. It owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It produces mult_div_stall, which the stall unit consumes to freeze the pipeline when an instruction needs HI/LO, or needs the unit, while an operation is in flight.

---
 rtl/mips_md_pkg.sv | 20 ++
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 142 ++++++++++++++
 tb/tb_mult_div_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_md_pkg.sv
// Shared encodings for the multiply/divide unit, its decoder and the stall unit.
package mips_md_pkg;

    typedef enum logic [2:0] {
        MD_NOP   = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage <-> multiply/divide unit connection, including HI/LO and stall outputs.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             hilo_read;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             mult_div_stall;

    modport master (
        output start, op, op_a, op_b, hilo_read,
        input  hi, lo, busy, mult_div_stall
    );

    modport slave (
        input  start, op, op_a, op_b, hilo_read,
        output hi, lo, busy, mult_div_stall
    );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and restoring divide
// share one 2*WIDTH shift register, followed by a one-cycle sign fix-up.
module mult_div_unit
    import mips_md_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           reset_n,
    mult_div_unit_if.slave md
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               is_mul, is_div, is_signed, md_start, a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rem;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    always_comb begin
        is_mul    = (md.op == MD_MULT) || (md.op == MD_MULTU);
        is_div    = (md.op == MD_DIV) || (md.op == MD_DIVU);
        is_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
        md_start  = md.start && (is_mul || is_div);
        a_neg     = is_signed && md.op_a[WIDTH-1];
        b_neg     = is_signed && md.op_b[WIDTH-1];
        abs_a     = a_neg ? -md.op_a : md.op_a;
        abs_b     = b_neg ? -md.op_b : md.op_b;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        // Divide: acc = {partial remainder, dividend bits / quotient bits}.
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        quo  = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        prod = neg_q ? -acc_q : acc_q;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (md_start) state_d = StCalc;
            StCalc:  if (cnt_q == '0) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            StIdle: begin
                if (md_start) begin
                    cnt_d     = CNT_W'(WIDTH - 1);
                    is_div_d  = is_div;
                    neg_d     = a_neg ^ b_neg;
                    rem_neg_d = is_div && a_neg;
                    acc_d     = is_div ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    opnd_d    = is_div ? abs_b : abs_a;
                end else if (md.start && md.op == MD_MTHI) begin
                    hi_d = md.op_a;
                end else if (md.start && md.op == MD_MTLO) begin
                    lo_d = md.op_a;
                end
            end
            StCalc: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            StFix: begin
                if (is_div_q) begin
                    // A zero divisor leaves an all-ones quotient that must not be negated.
                    lo_d = (neg_q && opnd_q != '0) ? -quo : quo;
                    hi_d = rem_neg_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = prod;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Outputs
    always_comb begin
        md.busy           = (state_q != StIdle);
        md.mult_div_stall = md.busy && (md.start || md.hilo_read);
        md.hi             = hi_q;
        md.lo             = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;
    import mips_md_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(WIDTH)) md ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .md      (md)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ua, ub;
        longint sa, sb;
        int ia, ib;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            MD_MULTU: return ua * ub;
            MD_MULT:  return 64'(sa * sb);
            MD_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            MD_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default:  return {mhi, mlo};
        endcase
    endfunction

    // Monitor: a completed operation is signalled by busy falling.
    int busy_cycles = 0;
    logic prev_busy = 1'b0;
    logic [63:0] mon_exp;
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cycles = 0;
            prev_busy = 1'b0;
        end else begin
            if (md.busy) begin
                busy_cycles++;
            end else if (prev_busy) begin
                check("busy_len", 64'(busy_cycles), 64'd33);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result: got %h with no expected entry", {md.hi, md.lo});
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("hilo", {md.hi, md.lo}, mon_exp);
                end
                busy_cycles = 0;
            end
            prev_busy = md.busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (md.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (md.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b required 0", md.busy);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        @(negedge clk);
        wait_idle();
        md.start = 1'b1;
        md.op    = op;
        md.op_a  = a;
        md.op_b  = b;
        @(posedge clk);
        if (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
            r = ref_model(op, a, b);
            exp_q.push_back(r);
            mhi = r[63:32];
            mlo = r[31:0];
        end else if (op == MD_MTHI) begin
            mhi = a;
        end else if (op == MD_MTLO) begin
            mlo = a;
        end
        #1;
        md.start = 1'b0;
        md.op    = MD_NOP;
        md.op_a  = $urandom;
        md.op_b  = $urandom;
    endtask

    task automatic wait_done();
        @(negedge clk);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int n;

        md.start     = 1'b0;
        md.op        = MD_NOP;
        md.op_a      = '0;
        md.op_b      = '0;
        md.hilo_read = 1'b0;
        #1;
        check("reset_hilo", {md.hi, md.lo}, 64'h0);
        check("reset_busy", {63'b0, md.busy}, 64'h0);
        check("reset_stall", {63'b0, md.mult_div_stall}, 64'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        check("multu_max", {md.hi, md.lo}, 64'hFFFF_FFFE_0000_0001);

        issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done();
        check("mult_neg", {md.hi, md.lo}, 64'hFFFF_FFFF_FFFF_FFF1);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        check("div_neg", {md.hi, md.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        issue(MD_DIVU, 32'd100, 32'd0);
        wait_done();
        check("divu_zero", {md.hi, md.lo}, 64'h0000_0064_FFFF_FFFF);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        check("div_ovf", {md.hi, md.lo}, 64'h0000_0000_8000_0000);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done();
        check("div_neg_zero", {md.hi, md.lo}, 64'hFFFF_FFF9_FFFF_FFFF);

        // hilo_read held through an operation
        issue(MD_MULT, $urandom, $urandom);
        md.hilo_read = 1'b1;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!md.mult_div_stall) break;
            n++;
        end
        check("read_stall_len", 64'(n), 64'd33);
        check("read_hilo", {md.hi, md.lo}, {mhi, mlo});
        md.hilo_read = 1'b0;

        // MTLO while idle
        @(negedge clk);
        md.start = 1'b1;
        md.op    = MD_MTLO;
        md.op_a  = 32'h1234;
        #1;
        check("mtlo_stall", {63'b0, md.mult_div_stall}, 64'h0);
        @(posedge clk);
        #1;
        md.start = 1'b0;
        mlo = 32'h1234;
        check("mtlo_lo", {32'b0, md.lo}, 64'h1234);
        check("mtlo_busy", {63'b0, md.busy}, 64'h0);

        // MTHI presented while busy: held until the unit idles
        issue(MD_DIVU, $urandom, $urandom_range(1, 1000));
        md.start = 1'b1;
        md.op    = MD_MTHI;
        md.op_a  = 32'hCAFE_F00D;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!md.busy) break;
            if (md.mult_div_stall) n++;
        end
        check("mthi_stall_len", 64'(n), 64'd33);
        @(posedge clk);
        #1;
        md.start = 1'b0;
        md.op    = MD_NOP;
        mhi = 32'hCAFE_F00D;
        check("mthi_after_op", {md.hi, md.lo}, {mhi, mlo});

        // Reset mid-operation
        issue(MD_DIVU, $urandom, $urandom_range(1, 50));
        repeat (10) @(negedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        mhi = '0;
        mlo = '0;
        #1;
        check("rst_busy", {63'b0, md.busy}, 64'h0);
        check("rst_hilo", {md.hi, md.lo}, 64'h0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        issue(MD_DIVU, 32'd9, 32'd2);
        wait_done();
        check("divu_after_rst", {md.hi, md.lo}, 64'h0000_0001_0000_0004);

        // Randomized operations, operand buses scrambled while busy
        for (int i = 0; i < 48; i++) begin
            case ($urandom_range(0, 9))
                0:       rop = MD_NOP;
                1:       rop = 3'd7;
                2, 3:    rop = MD_MULT;
                4, 5:    rop = MD_MULTU;
                6, 7:    rop = MD_DIV;
                default: rop = MD_DIVU;
            endcase
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = $urandom_range(1, 16);
                2: rb = -$urandom_range(1, 16);
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            issue(rop, ra, rb);
            if (rop == MD_NOP || rop == 3'd7) begin
                @(negedge clk);
                check("undef_op", {md.hi, md.lo, 31'b0, md.busy}, {mhi, mlo, 32'b0});
            end
        end
        wait_done();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
